// File: rtl/ram_march_pkg.sv
// Shared types for the RAM march self-test driver.
// Contents: FSM state encoding and per-cycle RAM operation codes.
package ram_march_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W0,
      R0W1,
      R1,
      DRAIN,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_WR,
      OP_RD
   } op_t;

endpackage

// File: rtl/ram_march_driver_if.sv
// Single-port RAM bus between the march driver and one RAM instance.
// Ports: we, addr, data_in (driver to RAM); data_out (RAM to driver).
interface ram_march_driver_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);

   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (
      output we,
      output addr,
      output data_in,
      input  data_out
   );

   modport slave (
      input  we,
      input  addr,
      input  data_in,
      output data_out
   );

endinterface

// File: rtl/ram_march_checker.sv
// Read-data checker: delays expected word/address by the RAM read latency,
// compares, latches the first failing address, counts misses (saturating).
// Ports: clk, rst, clr, rd_vld/rd_exp/rd_addr (issued read), rdata,
// fail_addr, fail_count.
module ram_march_checker #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  rd_vld,
   input  logic [DATA_WIDTH-1:0] rd_exp,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [CNT_WIDTH-1:0]  fail_count
);

   localparam int L = READ_LATENCY;
   localparam logic [CNT_WIDTH-1:0] C_MAX = {CNT_WIDTH{1'b1}};

   logic                  vld_q [L];
   logic [DATA_WIDTH-1:0] exp_q [L];
   logic [ADDR_WIDTH-1:0] adr_q [L];
   logic                  miss;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < L; i++) vld_q[i] <= 1'b0;
      end else begin
         vld_q[0] <= rd_vld;
         for (int i = 1; i < L; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      exp_q[0] <= rd_exp;
      adr_q[0] <= rd_addr;
      for (int i = 1; i < L; i++) begin
         exp_q[i] <= exp_q[i-1];
         adr_q[i] <= adr_q[i-1];
      end
   end

   assign miss = vld_q[L-1] && (rdata != exp_q[L-1]);

   // A zero count means no miss seen yet this run; saturation never
   // returns the count to zero, so it doubles as the first-miss flag.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         fail_addr  <= '0;
         fail_count <= '0;
      end else if (miss) begin
         if (fail_count == '0) fail_addr <= adr_q[L-1];
         if (fail_count != C_MAX) begin
            fail_count <= fail_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/ram_march_driver.sv
// March self-test initiator: W0(P) up, R0(P)/W1(~P) up, R1(~P) down.
// Ports: clk, rst, start, pattern, busy, done, pass, fail_addr,
// fail_count, ram (RAM bus master).
module ram_march_driver
   import ram_march_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pattern,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [CNT_WIDTH-1:0]  fail_count,
   ram_march_driver_if.master    ram
);

   localparam logic [ADDR_WIDTH-1:0] A_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [1:0] D_LAST = 2'(READ_LATENCY - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  sub_q, sub_d;
   logic [1:0]            dcnt_q, dcnt_d;
   logic [DATA_WIDTH-1:0] pat_q, pat_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic                  pvld_q, pvld_d;
   op_t                   op;
   logic [DATA_WIDTH-1:0] rd_exp;
   logic                  clr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sub_q   <= 1'b0;
         dcnt_q  <= '0;
         pat_q   <= '0;
         din_q   <= '0;
         pvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sub_q   <= sub_d;
         dcnt_q  <= dcnt_d;
         pat_q   <= pat_d;
         din_q   <= din_d;
         pvld_q  <= pvld_d;
      end
   end

   // sub_q selects the R0W1 half-cycle: 0 = read, 1 = write back ~P.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sub_d   = sub_q;
      dcnt_d  = dcnt_q;
      pat_d   = pat_q;
      din_d   = din_q;
      pvld_d  = pvld_q;
      op      = OP_NOP;
      rd_exp  = pat_q;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = W0;
               addr_d  = '0;
               sub_d   = 1'b0;
               pat_d   = pattern;
               din_d   = pattern;
               pvld_d  = 1'b0;
               clr     = 1'b1;
            end
         end
         W0: begin
            op = OP_WR;
            if (addr_q == A_LAST) begin
               state_d = R0W1;
               addr_d  = '0;
               sub_d   = 1'b0;
               din_d   = ~pat_q;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         R0W1: begin
            if (!sub_q) begin
               op    = OP_RD;
               sub_d = 1'b1;
            end else begin
               op    = OP_WR;
               sub_d = 1'b0;
               if (addr_q == A_LAST) state_d = R1;
               else addr_d = addr_q + 1'b1;
            end
         end
         R1: begin
            op     = OP_RD;
            rd_exp = ~pat_q;
            if (addr_q == '0) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end else begin
               addr_d = addr_q - 1'b1;
            end
         end
         DRAIN: begin
            if (dcnt_q == D_LAST) state_d = DONE;
            else dcnt_d = dcnt_q + 2'd1;
         end
         DONE: begin
            pvld_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign pass        = (done || pvld_q) && (fail_count == '0);
   assign ram.we      = (op == OP_WR);
   assign ram.addr    = addr_q;
   assign ram.data_in = din_q;

   ram_march_checker #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .READ_LATENCY (READ_LATENCY),
      .CNT_WIDTH    (CNT_WIDTH)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .rd_vld     (op == OP_RD),
      .rd_exp     (rd_exp),
      .rd_addr    (addr_q),
      .rdata      (ram.data_out),
      .fail_addr  (fail_addr),
      .fail_count (fail_count)
   );

endmodule

// File: tb/tb_ram_march_driver.sv
// Randomized bench for ram_march_driver against a behavioural RAM with
// stuck-bit read faults and a read-order reference model.
`timescale 1ns/1ps
module tb_ram_march_driver;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int RL    = 1;
   localparam int CW    = 16;
   localparam int RL2   = 3;
   localparam int CW2   = 2;
   localparam int BUSY1 = 4 * DEPTH + RL + 1;
   localparam int BUSY2 = 4 * DEPTH + RL2 + 1;
   localparam int SAT2  = (1 << CW2) - 1;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } tr_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [DW-1:0]  pattern;
   logic           busy1, done1, pass1;
   logic [AW-1:0]  fail_addr1;
   logic [CW-1:0]  fail_count1;
   logic           busy2, done2, pass2;
   logic [AW-1:0]  fail_addr2;
   logic [CW2-1:0] fail_count2;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] mem   [DEPTH];
   logic [DW-1:0] and_m [DEPTH];
   logic [DW-1:0] or_m  [DEPTH];
   tr_t           exp_tr [$];

   always #5 clk = ~clk;

   ram_march_driver_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram1 ();
   ram_march_driver_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram2 ();

   ram_march_driver #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .READ_LATENCY(RL), .CNT_WIDTH(CW)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern),
      .busy(busy1), .done(done1), .pass(pass1),
      .fail_addr(fail_addr1), .fail_count(fail_count1),
      .ram(ram1.master)
   );

   ram_march_driver #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .READ_LATENCY(RL2), .CNT_WIDTH(CW2)
   ) u_sat (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern),
      .busy(busy2), .done(done2), .pass(pass2),
      .fail_addr(fail_addr2), .fail_count(fail_count2),
      .ram(ram2.master)
   );

   // Synchronous RAM, one cycle read latency, faults on the read path.
   always @(posedge clk) begin
      if (ram1.we) mem[ram1.addr] <= ram1.data_in;
      ram1.data_out <= (mem[ram1.addr] & and_m[ram1.addr])
                       | or_m[ram1.addr];
   end

   // Second RAM reads back all zeros.
   assign ram2.data_out = '0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_faults();
      for (int a = 0; a < DEPTH; a++) begin
         and_m[a] = '1;
         or_m[a]  = '0;
      end
   endtask

   task automatic random_faults();
      clear_faults();
      for (int a = 0; a < DEPTH; a++) begin
         if ($urandom_range(0, 5) == 0) begin
            int b;
            b = $urandom_range(0, DW - 1);
            if ($urandom_range(0, 1) == 1) or_m[a][b] = 1'b1;
            else and_m[a][b] = 1'b0;
         end
      end
   endtask

   function automatic logic [DW-1:0] seen(input int a,
                                          input logic [DW-1:0] w);
      return (w & and_m[a]) | or_m[a];
   endfunction

   // Reads happen in march order: up expecting P, then down expecting ~P.
   task automatic model(input logic [DW-1:0] p,
                        output int cnt, output int fa);
      logic [DW-1:0] np;
      np  = ~p;
      cnt = 0;
      fa  = 0;
      for (int a = 0; a < DEPTH; a++) begin
         if (seen(a, p) != p) begin
            if (cnt == 0) fa = a;
            cnt++;
         end
      end
      for (int a = DEPTH - 1; a >= 0; a--) begin
         if (seen(a, np) != np) begin
            if (cnt == 0) fa = a;
            cnt++;
         end
      end
   endtask

   task automatic build_trace(input logic [DW-1:0] p);
      tr_t t;
      exp_tr.delete();
      for (int a = 0; a < DEPTH; a++) begin
         t = '{we: 1'b1, a: AW'(a), d: p};
         exp_tr.push_back(t);
      end
      for (int a = 0; a < DEPTH; a++) begin
         t = '{we: 1'b0, a: AW'(a), d: '0};
         exp_tr.push_back(t);
         t = '{we: 1'b1, a: AW'(a), d: ~p};
         exp_tr.push_back(t);
      end
      for (int a = DEPTH - 1; a >= 0; a--) begin
         t = '{we: 1'b0, a: AW'(a), d: '0};
         exp_tr.push_back(t);
      end
      for (int i = 0; i < RL + 1; i++) begin
         t = '{we: 1'b0, a: '0, d: '0};
         exp_tr.push_back(t);
      end
   endtask

   task automatic run(input logic [DW-1:0] p, input bit poke);
      int cnt1, fa1, cnt2, fa2;
      int n1, n2, d1, d2, at1, at2, poke_at, idx;
      logic pass_at_done;
      logic [DW-1:0] np;
      tr_t obs;
      np = ~p;
      model(p, cnt1, fa1);
      cnt2 = ((p != '0) ? DEPTH : 0) + ((np != '0) ? DEPTH : 0);
      if (cnt2 > SAT2) cnt2 = SAT2;
      fa2 = (p != '0) ? 0 : DEPTH - 1;
      build_trace(p);
      poke_at = $urandom_range(3, BUSY1 - 3);
      pattern = p;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      pattern = DW'($urandom);
      n1 = 0; n2 = 0; d1 = 0; d2 = 0;
      at1 = -1; at2 = -1; idx = 0;
      pass_at_done = 1'b0;
      for (int cyc = 0; cyc < 400 && (busy1 || busy2); cyc++) begin
         if (busy1) begin
            n1++;
            obs.we = ram1.we;
            obs.a  = ram1.addr;
            obs.d  = ram1.we ? ram1.data_in : '0;
            if (idx < exp_tr.size()) chk("trace", obs, exp_tr[idx]);
            idx++;
         end
         if (done1) begin
            d1++;
            at1 = n1;
            pass_at_done = pass1;
         end
         if (busy2) n2++;
         if (done2) begin
            d2++;
            at2 = n2;
         end
         start = poke && (cyc == poke_at);
         @(negedge clk);
      end
      start = 1'b0;
      chk("timeout", {busy1, busy2}, 2'b00);
      chk("busy1_len", n1, BUSY1);
      chk("done1_pulses", d1, 1);
      chk("done1_pos", at1, BUSY1);
      chk("pass_at_done", pass_at_done, cnt1 == 0);
      chk("pass_held", pass1, cnt1 == 0);
      chk("fail_count1", fail_count1, cnt1);
      chk("fail_addr1", fail_addr1, fa1);
      chk("busy2_len", n2, BUSY2);
      chk("done2_pulses", d2, 1);
      chk("done2_pos", at2, BUSY2);
      chk("fail_count2", fail_count2, cnt2);
      chk("fail_addr2", fail_addr2, fa2);
      chk("pass2", pass2, 1'b0);
   endtask

   task automatic reset_mid();
      pattern = DW'($urandom);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      chk("r0w1_3rd", {busy1, ram1.we, ram1.addr}, {2'b10, AW'(1)});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", {busy1, busy2}, 2'b00);
      chk("rst_we", {ram1.we, ram2.we}, 2'b00);
      chk("rst_cnt", fail_count1, 0);
      chk("rst_addr", ram1.addr, 0);
      chk("rst_done", done1, 1'b0);
      @(negedge clk);
      chk("rst_idle", busy1, 1'b0);
   endtask

   task automatic start_with_rst();
      rst     = 1'b1;
      start   = 1'b1;
      pattern = DW'($urandom);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("start_rst_busy", {busy1, busy2}, 2'b00);
      repeat (2) @(negedge clk);
      chk("start_rst_idle", {busy1, ram1.we}, 2'b00);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      pattern = '0;
      clear_faults();
      for (int a = 0; a < DEPTH; a++) mem[a] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", busy1, 1'b0);
      chk("reset_done", done1, 1'b0);
      chk("reset_pass", pass1, 1'b0);
      chk("reset_fail_addr", fail_addr1, 0);
      chk("reset_fail_count", fail_count1, 0);
      chk("reset_we", ram1.we, 1'b0);
      chk("reset_addr", ram1.addr, 0);
      chk("reset_din", ram1.data_in, 0);

      clear_faults();
      run(8'hA5, 1'b0);

      clear_faults();
      and_m[5][0] = 1'b0;
      run(8'hA5, 1'b0);

      clear_faults();
      run(8'hFF, 1'b0);

      clear_faults();
      run(DW'($urandom), 1'b1);

      clear_faults();
      reset_mid();
      run(DW'($urandom), 1'b0);

      start_with_rst();

      for (int i = 0; i < 10; i++) begin
         random_faults();
         run(DW'($urandom), 1'($urandom_range(0, 1)));
      end

      clear_faults();
      run(8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
